// File: rtl/io_channel_dma_card.sv
// io_channel_dma_card: ISA-style I/O channel card. It decodes four host
// registers, inserts wait states, serves single-channel DMA, and buffers
// traffic between the host bus and local streaming ports with a TX FIFO
// and an RX FIFO.
module io_channel_dma_card #(
  parameter logic [9:0] BASE_ADDRESS = 10'h300,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         WAIT_CYCLES  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] address,
  input  logic [7:0]  data_bus,
  output logic [7:0]  data_bus_out,
  output logic        data_bus_out_enable,
  input  logic        io_read_n,
  input  logic        io_write_n,
  input  logic        address_enable_n,
  output logic        io_channel_ready,
  output logic        dma_request,
  input  logic        dma_acknowledge_n,
  input  logic        terminal_count_n,
  output logic        interrupt_request,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACTIVE} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        read_q, write_q;
  logic        acc_read, acc_dma, acc_tc, acc_rx_empty;
  logic [1:0]  acc_off;

  logic        dma_en, dma_dir, tc_irq_en, rx_irq_en;
  logic        tc_flag, overrun, underrun;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [AW:0] tx_count, rx_count;
  logic        tx_not_full, rx_not_empty;

  logic        rd_fall, wr_fall, dma_sel, host_sel, dma_start, host_start, start;
  logic        start_read;
  logic [1:0]  start_off;
  logic        strobe_now, strobe_prev, complete;
  logic        wr_done, tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]  status, read_value;
  logic        unused_bits;

  assign unused_bits = ^{address[19:10], data_bus[7:4]};

  assign tx_count     = tx_wr - tx_rd;
  assign rx_count     = rx_wr - rx_rd;
  assign tx_not_full  = (tx_count != DEPTH_C);
  assign rx_not_empty = (rx_count != '0);
  assign tx_valid     = (tx_count != '0);
  assign rx_ready     = (rx_count != DEPTH_C);
  assign tx_data      = tx_mem[tx_rd[AW-1:0]];

  // Access decode: a DMA select (AEN high) can never coincide with a host
  // select (AEN low), so DMA naturally wins and the host path is ignored.
  assign rd_fall    = read_q & ~io_read_n;
  assign wr_fall    = write_q & ~io_write_n;
  assign dma_sel    = ~dma_acknowledge_n & address_enable_n;
  assign host_sel   = ~address_enable_n & (address[9:2] == BASE_ADDRESS[9:2]);
  assign dma_start  = dma_sel & (dma_dir ? rd_fall : wr_fall);
  assign host_start = ~dma_sel & host_sel & (rd_fall | wr_fall);
  assign start      = (state == ST_IDLE) & (dma_start | host_start);
  assign start_read = dma_start ? dma_dir : rd_fall;
  assign start_off  = dma_start ? 2'd0 : address[1:0];

  assign strobe_now  = acc_read ? io_read_n : io_write_n;
  assign strobe_prev = acc_read ? read_q : write_q;
  assign complete    = (state != ST_IDLE) & strobe_now & ~strobe_prev;

  assign wr_done     = complete & ~acc_read;
  assign tx_push_req = wr_done & (acc_off == 2'd0);
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push     = tx_push_req & (tx_not_full | tx_pop);
  assign rx_push     = rx_valid & rx_ready;
  assign rx_pop      = complete & acc_read & (acc_off == 2'd0) & ~acc_rx_empty;

  assign status = {interrupt_request, 2'b00, underrun, overrun, tc_flag, tx_not_full, rx_not_empty};

  // Read data is chosen when the strobe falls and then held for the whole strobe.
  always_comb begin
    read_value = 8'h00;
    case (start_off)
      2'd0:    read_value = rx_not_empty ? rx_mem[rx_rd[AW-1:0]] : 8'hFF;
      2'd1:    read_value = status;
      2'd2:    read_value = {4'b0000, rx_irq_en, tc_irq_en, dma_dir, dma_en};
      default: read_value = 8'h00;
    endcase
  end

  // Previous strobe levels; cleared by reset so a strobe held low across reset is not taken as a new edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      read_q  <= io_read_n;
      write_q <= io_write_n;
    end
  end

  // Strobe FSM: latches the access, inserts wait states and drives the bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= ST_IDLE;
      wait_cnt            <= '0;
      io_channel_ready    <= 1'b1;
      data_bus_out        <= '0;
      data_bus_out_enable <= 1'b0;
      acc_read            <= 1'b0;
      acc_dma             <= 1'b0;
      acc_tc              <= 1'b0;
      acc_rx_empty        <= 1'b0;
      acc_off             <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_read            <= start_read;
            acc_dma             <= dma_start;
            acc_off             <= start_off;
            acc_tc              <= dma_start & ~terminal_count_n;
            acc_rx_empty        <= ~rx_not_empty;
            data_bus_out_enable <= start_read;
            if (start_read) data_bus_out <= read_value;
            if (WAIT_CYCLES == 0) begin
              state <= ST_ACTIVE;
            end else begin
              state            <= ST_WAIT;
              io_channel_ready <= 1'b0;
              wait_cnt         <= 8'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (complete) begin
            state               <= ST_IDLE;
            io_channel_ready    <= 1'b1;
            data_bus_out_enable <= 1'b0;
          end else if (wait_cnt == 8'd0) begin
            state            <= ST_ACTIVE;
            io_channel_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        ST_ACTIVE: begin
          if (complete) begin
            state               <= ST_IDLE;
            data_bus_out_enable <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Control register and sticky flags, updated when an access completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dma_en    <= 1'b0;
      dma_dir   <= 1'b0;
      tc_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
      tc_flag   <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (wr_done && !acc_dma) begin
        case (acc_off)
          2'd2: {rx_irq_en, tc_irq_en, dma_dir, dma_en} <= data_bus[3:0];
          2'd3: begin
            tc_flag  <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
          end
          default: ;
        endcase
      end
      if (tx_push_req && !tx_push) overrun <= 1'b1;
      if (complete && acc_read && (acc_off == 2'd0) && acc_rx_empty) underrun <= 1'b1;
      if (complete && acc_dma && acc_tc) begin
        tc_flag <= 1'b1;
        dma_en  <= 1'b0;
      end
    end
  end

  // Registered interrupt and DMA request; DRQ is held low while any access is in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      interrupt_request <= 1'b0;
      dma_request       <= 1'b0;
    end else begin
      interrupt_request <= (tc_irq_en & tc_flag) | (rx_irq_en & rx_not_empty);
      dma_request       <= (state == ST_IDLE) & ~start & dma_en &
                           (dma_dir ? rx_not_empty : tx_not_full);
    end
  end

  // FIFO pointers; one extra bit distinguishes full from empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr <= '0;
      tx_rd <= '0;
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
    end
  end

  // FIFO storage needs no reset; validity is carried by the pointers.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= data_bus;
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_io_channel_dma_card.sv
// Testbench for io_channel_dma_card: directed sequence with random data,
// checked against a queue-based model of the card's register behaviour.
module tb_io_channel_dma_card;
  localparam int DEPTH = 16;
  localparam int WAITS = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [19:0] address;
  logic [7:0]  data_bus;
  logic [7:0]  data_bus_out;
  logic        data_bus_out_enable;
  logic        io_read_n, io_write_n, address_enable_n;
  logic        io_channel_ready, dma_request, dma_acknowledge_n, terminal_count_n;
  logic        interrupt_request;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;

  io_channel_dma_card #(.BASE_ADDRESS(10'h300), .FIFO_DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .data_bus(data_bus),
    .data_bus_out(data_bus_out), .data_bus_out_enable(data_bus_out_enable),
    .io_read_n(io_read_n), .io_write_n(io_write_n), .address_enable_n(address_enable_n),
    .io_channel_ready(io_channel_ready), .dma_request(dma_request),
    .dma_acknowledge_n(dma_acknowledge_n), .terminal_count_n(terminal_count_n),
    .interrupt_request(interrupt_request), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic m_en, m_dir, m_tcie, m_rxie, m_tc, m_ov, m_un;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic expIrq();
    return (m_tcie & m_tc) | (m_rxie & (rx_q.size() > 0));
  endfunction

  function automatic logic [7:0] expStatus();
    return {expIrq(), 2'b00, m_un, m_ov, m_tc, (tx_q.size() < DEPTH), (rx_q.size() > 0)};
  endfunction

  function automatic logic [7:0] expCtrl();
    return {4'b0000, m_rxie, m_tcie, m_dir, m_en};
  endfunction

  task automatic modelReset();
    tx_q.delete();
    rx_q.delete();
    {m_en, m_dir, m_tcie, m_rxie, m_tc, m_ov, m_un} = '0;
  endtask

  // Drives one complete bus cycle and reports what the card did during it.
  task automatic applyStimulus(input bit isDma, input bit isRead, input logic [19:0] addr,
                               input logic [7:0] wdata, input bit tc, input bit early, input bit popAtEnd,
                               output logic [7:0] rdata, output logic oeDuring, output logic oeAfter,
                               output logic dreqFirst, output int lows);
    @(negedge clock);
    address           = addr;
    address_enable_n  = isDma;
    dma_acknowledge_n = !isDma;
    terminal_count_n  = !tc;
    data_bus          = wdata;
    if (isRead) io_read_n = 1'b0; else io_write_n = 1'b0;
    lows      = 0;
    dreqFirst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 0) dreqFirst = dma_request;
      if (io_channel_ready) break;
      lows++;
      if (early) break;
    end
    rdata    = data_bus_out;
    oeDuring = data_bus_out_enable;
    if (popAtEnd) tx_ready = 1'b1;
    io_read_n  = 1'b1;
    io_write_n = 1'b1;
    @(negedge clock);
    tx_ready          = 1'b0;
    address_enable_n  = 1'b1;
    dma_acknowledge_n = 1'b1;
    terminal_count_n  = 1'b1;
    oeAfter = data_bus_out_enable;
  endtask

  task automatic hostWrite(input string tag, input logic [1:0] off, input logic [7:0] d,
                           input bit early, input bit pop);
    logic [7:0] rd;
    logic oe1, oe2, dq;
    int lows;
    applyStimulus(1'b0, 1'b0, {10'($urandom), 8'hC0, off}, d, 1'b0, early, pop, rd, oe1, oe2, dq, lows);
    checkOutput({tag, "_waits"}, lows, early ? 1 : WAITS);
    checkOutput({tag, "_oe"}, {oe1, oe2}, 2'b00);
    if (pop && tx_q.size() > 0) void'(tx_q.pop_front());
    case (off)
      2'd0: if (tx_q.size() < DEPTH) tx_q.push_back(d); else m_ov = 1'b1;
      2'd2: {m_rxie, m_tcie, m_dir, m_en} = d[3:0];
      2'd3: {m_tc, m_ov, m_un} = 3'b000;
      default: ;
    endcase
  endtask

  task automatic hostRead(input string tag, input logic [1:0] off);
    logic [7:0] rd, expv;
    logic oe1, oe2, dq;
    int lows;
    case (off)
      2'd0:    expv = (rx_q.size() > 0) ? rx_q[0] : 8'hFF;
      2'd1:    expv = expStatus();
      2'd2:    expv = expCtrl();
      default: expv = 8'h00;
    endcase
    applyStimulus(1'b0, 1'b1, {10'($urandom), 8'hC0, off}, 8'h00, 1'b0, 1'b0, 1'b0, rd, oe1, oe2, dq, lows);
    checkOutput({tag, "_data"}, rd, expv);
    checkOutput({tag, "_oe"}, {oe1, oe2}, 2'b10);
    if (off == 2'd0) begin
      if (rx_q.size() > 0) void'(rx_q.pop_front()); else m_un = 1'b1;
    end
  endtask

  task automatic dmaCycle(input string tag, input bit isRead, input logic [7:0] d, input bit tc);
    logic [7:0] rd, expv;
    logic oe1, oe2, dq;
    int lows;
    expv = (rx_q.size() > 0) ? rx_q[0] : 8'hFF;
    applyStimulus(1'b1, isRead, 20'($urandom), d, tc, 1'b0, 1'b0, rd, oe1, oe2, dq, lows);
    checkOutput({tag, "_drq_drop"}, dq, 1'b0);
    checkOutput({tag, "_waits"}, lows, WAITS);
    if (isRead) begin
      checkOutput({tag, "_data"}, rd, expv);
      if (rx_q.size() > 0) void'(rx_q.pop_front()); else m_un = 1'b1;
    end else begin
      if (tx_q.size() < DEPTH) tx_q.push_back(d); else m_ov = 1'b1;
    end
    if (tc) begin
      m_tc = 1'b1;
      m_en = 1'b0;
    end
  endtask

  task automatic checkState(input string tag);
    @(negedge clock);
    checkOutput({tag, "_txv"}, tx_valid, tx_q.size() > 0);
    if (tx_q.size() > 0) checkOutput({tag, "_txd"}, tx_data, tx_q[0]);
    checkOutput({tag, "_rxr"}, rx_ready, rx_q.size() < DEPTH);
    checkOutput({tag, "_irq"}, interrupt_request, expIrq());
    checkOutput({tag, "_drq"}, dma_request,
                m_en & (m_dir ? (rx_q.size() > 0) : (tx_q.size() < DEPTH)));
    checkOutput({tag, "_rdy"}, io_channel_ready, 1'b1);
  endtask

  task automatic rxPush(input string tag, input logic [7:0] d);
    @(negedge clock);
    checkOutput({tag, "_rxr"}, rx_ready, rx_q.size() < DEPTH);
    rx_valid = 1'b1;
    rx_data  = d;
    @(negedge clock);
    rx_valid = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(d);
  endtask

  task automatic txDrain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      checkOutput({tag, "_txv"}, tx_valid, tx_q.size() > 0);
      checkOutput({tag, "_txd"}, tx_data, tx_q[0]);
      tx_ready = 1'b1;
      @(negedge clock);
      tx_ready = 1'b0;
      void'(tx_q.pop_front());
    end
  endtask

  initial begin
    reset_n = 1'b1; address = '0; data_bus = '0; io_read_n = 1'b1; io_write_n = 1'b1;
    address_enable_n = 1'b1; dma_acknowledge_n = 1'b1; terminal_count_n = 1'b1;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    modelReset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_outputs",
                {io_channel_ready, data_bus_out, data_bus_out_enable, dma_request, interrupt_request, tx_valid, rx_ready},
                {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    reset_n = 1'b1;
    checkState("rst_idle");

    $display("[TB] host write 0xA5 to 0x300");
    hostWrite("w_a5", 2'd0, 8'hA5, 1'b0, 1'b0);
    checkState("w_a5");
    checkOutput("w_a5_txdata", tx_data, 8'hA5);
    txDrain("drain_a5", 1);

    $display("[TB] random host writes to TX");
    for (int i = 0; i < 6; i++) hostWrite("w_rand", 2'd0, 8'($urandom), 1'b0, 1'b0);
    hostRead("st_rand", 2'd1);
    txDrain("drain_rand", 6);
    hostWrite("ctrl_w", 2'd2, 8'($urandom) & 8'hFE, 1'b0, 1'b0);
    hostRead("ctrl_r", 2'd2);
    hostRead("off3_r", 2'd3);
    hostWrite("ctrl_clr", 2'd2, 8'h00, 1'b0, 1'b0);

    $display("[TB] fill RX, overflow, drain, underrun");
    for (int i = 0; i < DEPTH + 1; i++) rxPush("rx_fill", 8'($urandom));
    checkState("rx_full");
    hostRead("st_rxfull", 2'd1);
    for (int i = 0; i < DEPTH; i++) hostRead("rx_read", 2'd0);
    hostRead("rx_under", 2'd0);
    hostRead("st_under", 2'd1);
    hostWrite("clr_flags", 2'd3, 8'($urandom), 1'b0, 1'b0);
    hostRead("st_clr", 2'd1);
    checkOutput("st_clr_model", expStatus(), 8'h02);

    $display("[TB] RX interrupt");
    hostWrite("rxie", 2'd2, 8'h08, 1'b0, 1'b0);
    rxPush("rxie_push", 8'($urandom));
    checkState("rxie_on");
    hostRead("rxie_pop", 2'd0);
    checkState("rxie_off");

    $display("[TB] DMA writes with terminal count");
    hostWrite("dma_ctrl", 2'd2, 8'h05, 1'b0, 1'b0);
    checkState("dma_armed");
    for (int i = 0; i < 3; i++) begin
      dmaCycle("dma_wr", 1'b0, 8'($urandom), i == 2);
      checkState("dma_wr");
    end
    hostRead("dma_ctrl_r", 2'd2);
    hostRead("dma_st", 2'd1);
    hostWrite("dma_clr", 2'd3, 8'h00, 1'b0, 1'b0);
    checkState("dma_clr");
    txDrain("dma_drain", 3);

    $display("[TB] DMA reads and ignored strobe");
    hostWrite("dmar_ctrl", 2'd2, 8'h03, 1'b0, 1'b0);
    rxPush("dmar_push", 8'($urandom));
    rxPush("dmar_push", 8'($urandom));
    checkState("dmar_armed");
    begin
      logic [7:0] rd; logic o1, o2, dq; int lows;
      applyStimulus(1'b1, 1'b0, 20'($urandom), 8'h77, 1'b0, 1'b0, 1'b0, rd, o1, o2, dq, lows);
      checkOutput("dmar_ignored_wr", lows, 0);
    end
    dmaCycle("dmar", 1'b1, 8'h00, 1'b0);
    dmaCycle("dmar", 1'b1, 8'h00, 1'b0);
    checkState("dmar_done");
    hostWrite("dmar_off", 2'd2, 8'h00, 1'b0, 1'b0);

    $display("[TB] TX full with simultaneous pop, then overrun");
    for (int i = 0; i < DEPTH; i++) hostWrite("fill_tx", 2'd0, 8'($urandom), 1'b0, 1'b0);
    hostWrite("push_pop", 2'd0, 8'($urandom), 1'b0, 1'b1);
    hostRead("st_pushpop", 2'd1);
    hostWrite("ovr", 2'd0, 8'($urandom), 1'b0, 1'b0);
    hostRead("st_ovr", 2'd1);
    txDrain("drain_full", DEPTH);
    hostWrite("clr_ovr", 2'd3, 8'h00, 1'b0, 1'b0);

    $display("[TB] early strobe release during WAIT");
    hostWrite("early", 2'd0, 8'($urandom), 1'b1, 1'b0);
    checkState("early");
    txDrain("early_drain", 1);

    $display("[TB] reset during WAIT");
    rxPush("pre_rst", 8'($urandom));
    @(negedge clock);
    address = 20'h00300; address_enable_n = 1'b0; data_bus = 8'h3C; io_write_n = 1'b0;
    @(negedge clock);
    checkOutput("rst_mid_wait", io_channel_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_rdy", io_channel_ready, 1'b1);
    checkOutput("rst_mid_fifos", {tx_valid, rx_ready}, 2'b01);
    modelReset();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_no_restart", io_channel_ready, 1'b1);
    io_write_n = 1'b1;
    address_enable_n = 1'b1;
    checkState("rst_after");
    hostRead("rst_status", 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: observed no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/io_channel_dma_card.md
IO_CHANNEL_DMA_CARD -- requirements
Module: io_channel_dma_card

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 10'h300, I/O base; decode uses address[9:2].
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries per FIFO (power of 2).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, clocks io_channel_ready is held low per access.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports are clock and reset_n.
REQ-005 Ports:
  clock               in   1   system clock, shared with the chipset
  reset_n             in   1   async active-low reset
  address             in   20  channel address
  data_bus            in   8   channel data from host
  data_bus_out        out  8   read data to host
  data_bus_out_enable out  1   card drives the data bus
  io_read_n           in   1   I/O read strobe
  io_write_n          in   1   I/O write strobe
  address_enable_n    in   1   low = CPU cycle; high = DMA cycle
  io_channel_ready    out  1   low = insert wait states
  dma_request         out  1   DRQ to the DMA controller
  dma_acknowledge_n   in   1   DACK for this card's channel
  terminal_count_n    in   1   low on the final DMA transfer
  interrupt_request   out  1   IRQ line, active high
  tx_data             out  8   local stream out, TX FIFO head
  tx_valid            out  1   TX FIFO not empty
  tx_ready            in   1   local sink takes tx_data
  rx_data             in   8   local stream in
  rx_valid            in   1   rx_data valid
  rx_ready            out  1   RX FIFO not full

Function
REQ-006 Host select SHALL be: address_enable_n=0 and address[9:2]=BASE_ADDRESS[9:2]. DMA select SHALL be: dma_acknowledge_n=0 and address_enable_n=1.
REQ-007 Registers SHALL be mapped by offset (address[1:0]):
  - 0: read pops RX FIFO; write pushes TX FIFO.
  - 1: read returns STATUS = {irq_pending, 2'b0, underrun, overrun, tc_flag, tx_not_full, rx_not_empty}.
  - 2: CTRL, read/write. bit0 dma_en; bit1 dma_dir (0: host to TX, 1: RX to host); bit2 tc_irq_en; bit3 rx_irq_en.
  - 3: any write clears tc_flag, overrun, underrun; read returns 8'h00.
REQ-008 Strobe FSM states SHALL be IDLE, WAIT, ACTIVE, with strobes sampled each clock.
  - IDLE -> WAIT: on a selected io_read_n or io_write_n falling edge (1 -> 0).
  - WAIT: io_channel_ready=0 for exactly WAIT_CYCLES clocks, then ACTIVE.
  - ACTIVE: io_channel_ready=1; -> IDLE when the strobe returns high.
  - WAIT_CYCLES=0: IDLE goes directly to ACTIVE.
REQ-009 Write data SHALL be captured on the clock the strobe is sampled high again (rising edge); the register or FIFO update follows on that same clock.
REQ-010 For a read, data_bus_out_enable SHALL be 1 from the falling edge through the last low clock of the strobe.
REQ-011 data_bus_out SHALL hold stable read data for the whole strobe. An RX pop SHALL occur on the strobe rising edge.
REQ-012 TX push when full SHALL drop the data and set overrun.
REQ-013 RX pop when empty SHALL return 8'hFF and set underrun.
REQ-014 Simultaneous push and pop on one FIFO in one clock SHALL both take effect, with the count unchanged.
REQ-015 Local side SHALL be:
  - tx_valid = TX not empty; tx pops when tx_valid and tx_ready are both 1.
  - rx_ready = RX not full; rx pushes when rx_valid and rx_ready are both 1.
REQ-016 dma_request SHALL be 1 when idle and dma_en=1 and either: dma_dir=0 with TX not full, or dma_dir=1 with RX not empty.
REQ-017 dma_request SHALL drop the clock after a DMA strobe falling edge, and re-evaluate after that strobe rises.
REQ-018 DMA SHALL use io_write_n when dma_dir=0 and io_read_n when dma_dir=1; the opposite strobe is ignored.
REQ-019 If terminal_count_n is low at a DMA strobe falling edge, then after that transfer completes: tc_flag SHALL be set, dma_en SHALL clear, and dma_request SHALL fall.
REQ-020 interrupt_request SHALL equal (tc_irq_en & tc_flag) | (rx_irq_en & rx_not_empty), registered. irq_pending SHALL mirror it.
REQ-021 If host and DMA select occur together, DMA SHALL win and the host access SHALL be ignored.
REQ-022 A strobe rising early, during WAIT, SHALL still complete the access, and the FSM SHALL return to IDLE.

Reset
REQ-023 While reset_n=0, asynchronously:
  - both FIFOs empty; CTRL=0; all flags 0; FSM=IDLE.
  - io_channel_ready=1; data_bus_out=0; data_bus_out_enable=0; dma_request=0; interrupt_request=0; tx_valid=0; rx_ready=1.
REQ-024 Reset asserted mid-access SHALL abort it with no FIFO or register update. After release, the FSM SHALL wait for a new falling edge.

Verification
REQ-025 Host write 8'hA5 to 0x300 with WAIT_CYCLES=2 -> io_channel_ready low exactly 2 clocks; tx_valid=1 and tx_data=8'hA5 after the strobe rises.
REQ-026 Push 16 rx bytes; a 17th rx_valid -> rx_ready=0, and the 17th byte is not stored. Read STATUS -> bit0=1.
REQ-027 Read 0x300 with RX empty -> data 8'hFF, underrun set. Write 0x303 -> STATUS=8'h02.
REQ-028 CTRL=8'h05, then 3 DMA writes with terminal_count_n low on the 3rd -> TX holds 3 bytes; dma_en=0; tc_flag=1; interrupt_request=1; dma_request=0.
REQ-029 Simultaneous tx pop and host TX push with TX full -> count stays 16, no overrun.
REQ-030 reset_n low during WAIT -> io_channel_ready=1 immediately; FIFOs empty; no write committed.
